index_frame_reader: RTL and testbench
=====================================

// Module: index_frame_reader
// PURPOSE
// - Scan-out side of the 640x480 colour-index framebuffer that the character typer fills.
// - Generates VGA h/v timing and issues sequential read addresses to the index memory.
// - Returns each 3-bit colour index aligned with its delayed hsync, vsync and active flags.
// - Sits between the framebuffer read port and the palette/DAC stage.
// PARAMETERS
// H_ACTIVE     640  visible pixels per line
// H_FP         16   horizontal front porch (pixels)
// H_SYNC       96   hsync width (pixels)
// H_BP         48   horizontal back porch (pixels)
// V_ACTIVE     480  visible lines per frame
// V_FP         10   vertical front porch (lines)
// V_SYNC       2    vsync width (lines)
// V_BP         33   vertical back porch (lines)
// MEM_LATENCY  2    framebuffer read latency in pixel_en ticks (1..4)
// PORTS
// clock        in   1   system clock, all logic on rising edge
// resetn       in   1   asynchronous, active-low reset
// pixel_en     in   1   pixel-rate enable; all state advances only when high
// mem_raddr    out  19  framebuffer read address, row-major: y*H_ACTIVE + x
// mem_rdata    in   3   framebuffer read data, valid MEM_LATENCY pixel_en ticks after address
// pixel_index  out  3   colour index to palette; 0 outside the active area
// hsync        out  1   horizontal sync, active low
// vsync        out  1   vertical sync, active low
// active       out  1   high when pixel_index is a visible pixel
// frame_start  out  1   one-clock pulse when (h,v) = (0,0) is issued
// BEHAVIOUR
// - Reset values: mem_raddr=0, pixel_index=0, hsync=1, vsync=1, active=0, frame_start=0.
// - Reset also clears h_cnt, v_cnt and the delay line.
// - Reset mid-frame aborts the frame; the first pixel_en after release issues (0,0).
// - h_cnt counts 0..H_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800 by default).
// - h_cnt wraps to 0 and increments v_cnt; v_cnt wraps 0..V_TOTAL-1 (525 by default).
// - Raw active = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
// - Raw hsync low for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1].
// - Raw vsync low for v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1].
// - Address generation uses an incremental counter; no multiplier.
//   - The counter advances by 1 on every raw-active pixel_en tick.
//   - It holds during blanking and clears to 0 at (h,v)=(0,0).
//   - Last visible address is 307199; it never exceeds that value.
// - mem_raddr is registered and holds its value between pixel_en ticks.
// - raw active, hsync and vsync pass through a MEM_LATENCY-deep delay line.
//   - The delay line shifts only on pixel_en.
//   - mem_rdata is captured on the same tick that the delayed flags leave the line.
// - pixel_index = delayed_active ? captured mem_rdata : 3'd0; total latency = MEM_LATENCY+1 ticks.
// - frame_start pulses for exactly one clock on the pixel_en tick that issues address 0 of a frame.
// - pixel_en low: every output and counter holds; frame_start stays 0.
// - Rollover cases: the h and v wrap on the same tick sends (799,524) to (0,0).
// CONFIGURATION
// - BORDER_DEBUG_EN defined:
//   - pixel_index is forced to 3'd7 on the outer row/column of the active area.
//   - This covers x=0, x=H_ACTIVE-1, y=0 and y=V_ACTIVE-1.
//   - Addresses and read traffic are unchanged.
// - BORDER_DEBUG_EN undefined: pixel_index always reflects mem_rdata in the active area.
// TESTING
// - Hold resetn=0 for 5 clocks -> hsync=1, vsync=1, active=0, pixel_index=0, mem_raddr=0.
// - Tie pixel_en=1 and model memory rdata=addr[2:0] with 2-clock latency:
//   - pixel_index sequence is 0,1,..,7,0,...
//   - active rises 3 clocks after frame_start.
// - Count clocks per line -> hsync low for 96 of 800 clocks, starting at h=656.
// - Count lines per frame -> vsync low for 2 of 525 lines, starting at v=490.
// - Check the last visible pixel -> mem_raddr=307199 at (639,479); next frame_start occurs after 420000 clocks.
// - Drive pixel_en at 1/2 rate and assert resetn=0 at (100,50):
//   - Outputs return to reset values asynchronously.
//   - Restart from address 0 with identical timing in ticks.
//   - With BORDER_DEBUG_EN defined, pixels (0,y) and (639,y) read 7.

Source files
------------

// File: rtl/index_frame_reader.sv
// VGA scan-out for the colour-index framebuffer: h/v timing, sequential read addressing,
// and pixel/sync alignment. Optional BORDER_DEBUG_EN paints the outer active ring with index 7.
module index_frame_reader #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned H_FP        = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BP        = 48,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned V_FP        = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BP        = 33,
  parameter int unsigned MEM_LATENCY = 2
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        pixel_en,
  output logic [18:0] mem_raddr,
  input  logic [2:0]  mem_rdata,
  output logic [2:0]  pixel_index,
  output logic        hsync,
  output logic        vsync,
  output logic        active,
  output logic        frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW      = $clog2(H_TOTAL);
  localparam int unsigned VW      = $clog2(V_TOTAL);
  localparam int unsigned ML      = MEM_LATENCY;

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_L  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_ACT_M1 = HW'(H_ACTIVE - 1);
  localparam logic [HW-1:0] HS_BEG   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_L  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_ACT_M1 = VW'(V_ACTIVE - 1);
  localparam logic [VW-1:0] VS_BEG   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

  // Coordinates of the pixel issued on the next pixel_en tick.
  logic [HW-1:0] r_h;
  logic [VW-1:0] r_v;

  logic w_first;
  logic w_h_last;
  logic w_v_last;
  logic w_raw_act;
  logic w_raw_hs;
  logic w_raw_vs;
  logic [2:0] w_pix_next;

  // Stage 0 is aligned with mem_raddr; stage ML meets the returning read data.
  logic [ML:0] r_act_dly;
  logic [ML:0] r_hs_dly;
  logic [ML:0] r_vs_dly;

`ifdef BORDER_DEBUG_EN
  logic        w_raw_bdr;
  logic [ML:0] r_bdr_dly;
`endif

  always_comb begin
    w_first   = (r_h == '0) && (r_v == '0);
    w_h_last  = (r_h == H_LAST);
    w_v_last  = (r_v == V_LAST);
    w_raw_act = (r_h < H_ACT_L) && (r_v < V_ACT_L);
    w_raw_hs  = !((r_h >= HS_BEG) && (r_h <= HS_END));
    w_raw_vs  = !((r_v >= VS_BEG) && (r_v <= VS_END));
  end

`ifdef BORDER_DEBUG_EN
  always_comb begin
    w_raw_bdr = w_raw_act &&
                ((r_h == '0) || (r_h == H_ACT_M1) || (r_v == '0) || (r_v == V_ACT_M1));
  end
`endif

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_h <= '0;
      r_v <= '0;
    end else if (pixel_en) begin
      if (w_h_last) begin
        r_h <= '0;
        r_v <= w_v_last ? '0 : r_v + VW'(1);
      end else begin
        r_h <= r_h + HW'(1);
      end
    end
  end

  // The address register doubles as the running counter: it restarts at (0,0),
  // steps on active pixels and parks on the last visible address through blanking.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      mem_raddr   <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= pixel_en && w_first;
      if (pixel_en) begin
        if (w_first) begin
          mem_raddr <= '0;
        end else if (w_raw_act) begin
          mem_raddr <= mem_raddr + 19'd1;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_act_dly <= '0;
      r_hs_dly  <= '1;
      r_vs_dly  <= '1;
    end else if (pixel_en) begin
      r_act_dly <= {r_act_dly[ML-1:0], w_raw_act};
      r_hs_dly  <= {r_hs_dly[ML-1:0], w_raw_hs};
      r_vs_dly  <= {r_vs_dly[ML-1:0], w_raw_vs};
    end
  end

`ifdef BORDER_DEBUG_EN
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_bdr_dly <= '0;
    end else if (pixel_en) begin
      r_bdr_dly <= {r_bdr_dly[ML-1:0], w_raw_bdr};
    end
  end

  always_comb begin
    w_pix_next = 3'd0;
    if (r_act_dly[ML]) begin
      w_pix_next = r_bdr_dly[ML] ? 3'd7 : mem_rdata;
    end
  end
`else
  always_comb begin
    w_pix_next = 3'd0;
    if (r_act_dly[ML]) begin
      w_pix_next = mem_rdata;
    end
  end
`endif

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pixel_index <= '0;
      active      <= 1'b0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
    end else if (pixel_en) begin
      pixel_index <= w_pix_next;
      active      <= r_act_dly[ML];
      hsync       <= r_hs_dly[ML];
      vsync       <= r_vs_dly[ML];
    end
  end

endmodule

// File: tb/tb_index_frame_reader.sv
// Scoreboard bench for index_frame_reader on a reduced raster; expected pixels come from
// closed-form frame arithmetic on the tick count since reset.
module tb_index_frame_reader;

  localparam int unsigned HA = 32, HF = 4, HS = 6, HB = 6;
  localparam int unsigned VA = 12, VF = 2, VS = 2, VB = 3;
  localparam int unsigned L  = 2;
  localparam int unsigned HT = HA + HF + HS + HB;
  localparam int unsigned VT = VA + VF + VS + VB;
  localparam int unsigned FRAME = HT * VT;

  typedef struct packed {
    logic       act;
    logic       hs;
    logic       vs;
    logic [2:0] pix;
  } pix_t;

  typedef struct packed {
    logic [18:0] addr;
    logic        fs;
  } iss_t;

  localparam pix_t RST = '{act: 1'b0, hs: 1'b1, vs: 1'b1, pix: 3'd0};

  logic        clock;
  logic        resetn;
  logic        pixel_en;
  logic [18:0] mem_raddr;
  logic [2:0]  mem_rdata;
  logic [2:0]  pixel_index;
  logic        hsync;
  logic        vsync;
  logic        active;
  logic        frame_start;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned k;
  pix_t q_pix[$];
  iss_t q_iss[$];
  logic [2:0] mpipe [L];

  index_frame_reader #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .MEM_LATENCY(L)
  ) dut (
    .clock(clock),
    .resetn(resetn),
    .pixel_en(pixel_en),
    .mem_raddr(mem_raddr),
    .mem_rdata(mem_rdata),
    .pixel_index(pixel_index),
    .hsync(hsync),
    .vsync(vsync),
    .active(active),
    .frame_start(frame_start)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Framebuffer stand-in: word at address A holds A[2:0], returned L pixel ticks later.
  always @(posedge clock) begin
    if (pixel_en) begin
      mpipe[0] <= mem_raddr[2:0];
      for (int i = 1; i < int'(L); i++) mpipe[i] <= mpipe[i-1];
    end
  end
  assign mem_rdata = mpipe[L-1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model(input int unsigned idx, output pix_t p, output iss_t s);
    int unsigned m, h, v, a;
    m = idx % FRAME;
    h = m % HT;
    v = m / HT;
    if (v >= VA)      a = VA * HA - 1;
    else if (h >= HA) a = v * HA + HA - 1;
    else              a = v * HA + h;
    p.act = (h < HA) && (v < VA);
    p.hs  = !((h >= HA + HF) && (h < HA + HF + HS));
    p.vs  = !((v >= VA + VF) && (v < VA + VF + VS));
    p.pix = p.act ? a[2:0] : 3'd0;
`ifdef BORDER_DEBUG_EN
    if (p.act && (h == 0 || h == HA - 1 || v == 0 || v == VA - 1)) p.pix = 3'd7;
`endif
    s.addr = a[18:0];
    s.fs   = (m == 0);
  endfunction

  task automatic flush();
    q_pix.delete();
    q_iss.delete();
    for (int i = 0; i <= int'(L); i++) q_pix.push_back(RST);
    k = 0;
  endtask

  task automatic issue(input bit pe);
    pix_t p;
    iss_t s;
    @(negedge clock);
    pixel_en = pe;
    if (pe) begin
      model(k, p, s);
      q_pix.push_back(p);
      q_iss.push_back(s);
      k++;
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_raddr"}, 32'(mem_raddr), 32'd0);
    chk({tag, "_pix"},   32'(pixel_index), 32'd0);
    chk({tag, "_hsync"}, 32'(hsync), 32'd1);
    chk({tag, "_vsync"}, 32'(vsync), 32'd1);
    chk({tag, "_active"}, 32'(active), 32'd0);
    chk({tag, "_fs"},    32'(frame_start), 32'd0);
  endtask

  // Monitor: one scoreboard entry per pixel_en tick; outputs must hold otherwise.
  initial begin
    pix_t cur_p;
    logic [18:0] cur_a;
    logic exp_fs;
    logic pe, rs;
    cur_p = RST;
    cur_a = '0;
    forever begin
      @(posedge clock);
      pe = pixel_en;
      rs = resetn;
      #1;
      exp_fs = 1'b0;
      if (!rs) begin
        cur_p = RST;
        cur_a = '0;
      end else if (pe) begin
        if (q_pix.size() == 0 || q_iss.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL scoreboard_empty: got %0d/%0d entries, expected >0 at %0t",
                   q_pix.size(), q_iss.size(), $time);
        end else begin
          iss_t s;
          cur_p  = q_pix.pop_front();
          s      = q_iss.pop_front();
          cur_a  = s.addr;
          exp_fs = s.fs;
        end
      end
      chk("raddr",  32'(mem_raddr),   32'(cur_a));
      chk("pix",    32'(pixel_index), 32'(cur_p.pix));
      chk("hsync",  32'(hsync),       32'(cur_p.hs));
      chk("vsync",  32'(vsync),       32'(cur_p.vs));
      chk("active", 32'(active),      32'(cur_p.act));
      chk("fs",     32'(frame_start), 32'(exp_fs));
    end
  end

  initial begin
    bit done;
    resetn   = 1'b0;
    pixel_en = 1'b0;
    k        = 0;
    repeat (5) @(negedge clock);
    chk_reset_vals("por");
    flush();
    @(negedge clock);
    resetn = 1'b1;

    repeat (2 * FRAME + 100) issue(1'b1);

    // Half-rate run from a fresh frame until pixel (20,5) has just been issued.
    done = 1'b0;
    while (!done) begin
      issue(1'b1);
      done = (((k - 1) % FRAME) == 5 * HT + 20);
      if (!done) issue(1'b0);
    end
    @(posedge clock);
    #3;
    resetn = 1'b0;
    #1;
    chk_reset_vals("async");
    flush();
    repeat (3) @(negedge clock);
    pixel_en = 1'b0;
    resetn   = 1'b1;

    repeat (2 * FRAME) issue(1'b1);
    issue(1'b0);
    for (int i = 0; i < int'(2 * FRAME); i++) issue($urandom_range(0, 2) != 0);
    repeat (L + 3) issue(1'b1);
    @(negedge clock);
    pixel_en = 1'b0;
    repeat (2) @(negedge clock);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
